// File: rtl/mdc_r2_trivial_stage.sv
// -----------------------------------------------------------------------------
// mdc_r2_trivial_stage
//   Radix-2 MDC FFT stage whose twiddles are trivial (1 and -j, or +j when
//   running the inverse transform).  A 2-lane complex stream is registered,
//   passed through a butterfly, lane 1 is rotated on alternate ROT_SPAN-sample
//   blocks, and the lanes are reordered by an L_STAGE-deep delay-commutator.
//
//   Pipeline:  S0 input register -> S1 butterfly/rotate/commutate (comb)
//              -> L_STAGE delay lines -> output register
//   Latency i_valid -> o_valid is L_STAGE+2 cycles.
//
//   Build option MDC_R2_ROUND_SCALE_EN:
//     defined     : every output part is (v+1)>>>1 of the S1 value,
//                   NB_OUTPUT = NB_INPUT
//     not defined : exact outputs, NB_OUTPUT = NB_INPUT+1
// -----------------------------------------------------------------------------
module mdc_r2_trivial_stage #(
    parameter int NB_INPUT  = 10,
`ifdef MDC_R2_ROUND_SCALE_EN
    parameter int NB_OUTPUT = 10,
`else
    parameter int NB_OUTPUT = 11,
`endif
    parameter int L_STAGE   = 1,
    parameter int ROT_SPAN  = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_inverse,
    input  logic                        i_valid,
    input  logic signed [NB_INPUT-1:0]  i_data1_r,
    input  logic signed [NB_INPUT-1:0]  i_data1_i,
    input  logic signed [NB_INPUT-1:0]  i_data2_r,
    input  logic signed [NB_INPUT-1:0]  i_data2_i,
    output logic                        o_valid,
    output logic signed [NB_OUTPUT-1:0] o_data1_r,
    output logic signed [NB_OUTPUT-1:0] o_data1_i,
    output logic signed [NB_OUTPUT-1:0] o_data2_r,
    output logic signed [NB_OUTPUT-1:0] o_data2_i
);

    // butterfly width: one growth bit, never overflows
    localparam int NBS = NB_INPUT + 1;
    // rc counts 0..2*ROT_SPAN-1, sc counts 0..2*L_STAGE-1
    localparam int RCW = $clog2(2 * ROT_SPAN);
    localparam int SCW = $clog2(2 * L_STAGE);

    // -------------------------------------------------------------------------
    // helpers
    // -------------------------------------------------------------------------
    function automatic logic signed [NBS-1:0] sx(input logic signed [NB_INPUT-1:0] v);
        return {v[NB_INPUT-1], v};
    endfunction

    // -(-2^NB_INPUT) is not representable; clamp it to the positive maximum
    function automatic logic signed [NBS-1:0] neg_sat(input logic signed [NBS-1:0] v);
        if (v == {1'b1, {(NBS-1){1'b0}}})
            return {1'b0, {(NBS-1){1'b1}}};
        return -v;
    endfunction

    // S1 value -> output format (optional round-half-up halving)
    function automatic logic signed [NB_OUTPUT-1:0] fmt(input logic signed [NBS-1:0] v);
`ifdef MDC_R2_ROUND_SCALE_EN
        logic signed [NBS:0] t;
        t = ($signed({v[NBS-1], v}) + $signed((NBS+1)'(1))) >>> 1;
        // only the saturated +max input can round up past the output range
        if (!t[NBS] && t[NB_OUTPUT-1])
            return {1'b0, {(NB_OUTPUT-1){1'b1}}};
        return t[NB_OUTPUT-1:0];
`else
        return v;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // S0: input register
    // -------------------------------------------------------------------------
    logic                       s0_valid;
    logic                       s0_inv;
    logic signed [NB_INPUT-1:0] s0_x0_r, s0_x0_i, s0_x1_r, s0_x1_i;

    // capture the input pair together with its valid and direction
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s0_valid <= 1'b0;
            s0_inv   <= 1'b0;
            s0_x0_r  <= '0;
            s0_x0_i  <= '0;
            s0_x1_r  <= '0;
            s0_x1_i  <= '0;
        end else begin
            s0_valid <= i_valid;
            s0_inv   <= i_inverse;
            s0_x0_r  <= i_data1_r;
            s0_x0_i  <= i_data1_i;
            s0_x1_r  <= i_data2_r;
            s0_x1_i  <= i_data2_i;
        end
    end

    // -------------------------------------------------------------------------
    // S1: butterfly, rotation, commutator switch
    // -------------------------------------------------------------------------
    logic [RCW-1:0] rc;
    logic [SCW-1:0] sc;

    // sample position within the frame; a valid gap restarts both counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rc <= '0;
            sc <= '0;
        end else if (s0_valid) begin
            rc <= rc + RCW'(1);
            sc <= sc + SCW'(1);
        end else begin
            rc <= '0;
            sc <= '0;
        end
    end

    logic signed [NBS-1:0] s1_a_r, s1_a_i, s1_b_r, s1_b_i;
    logic signed [NBS-1:0] s1_bp_r, s1_bp_i;

    assign s1_a_r = sx(s0_x0_r) + sx(s0_x1_r);
    assign s1_a_i = sx(s0_x0_i) + sx(s0_x1_i);
    assign s1_b_r = sx(s0_x0_r) - sx(s0_x1_r);
    assign s1_b_i = sx(s0_x0_i) - sx(s0_x1_i);

    // second half of each 2*ROT_SPAN block gets -j (forward) or +j (inverse)
    always_comb begin
        s1_bp_r = s1_b_r;
        s1_bp_i = s1_b_i;
        if (rc[RCW-1]) begin
            if (!s0_inv) begin
                s1_bp_r = s1_b_i;
                s1_bp_i = neg_sat(s1_b_r);
            end else begin
                s1_bp_r = neg_sat(s1_b_i);
                s1_bp_i = s1_b_r;
            end
        end
    end

    logic signed [NB_OUTPUT-1:0] s1_af_r, s1_af_i, s1_bf_r, s1_bf_i;

    assign s1_af_r = fmt(s1_a_r);
    assign s1_af_i = fmt(s1_a_i);
    assign s1_bf_r = fmt(s1_bp_r);
    assign s1_bf_i = fmt(s1_bp_i);

    // -------------------------------------------------------------------------
    // delay-commutator
    // -------------------------------------------------------------------------
    logic signed [NB_OUTPUT-1:0] a_dly_r [L_STAGE];
    logic signed [NB_OUTPUT-1:0] a_dly_i [L_STAGE];
    logic signed [NB_OUTPUT-1:0] y_dly_r [L_STAGE];
    logic signed [NB_OUTPUT-1:0] y_dly_i [L_STAGE];
    logic [L_STAGE-1:0]          v_dly;

    logic                        sw;
    logic signed [NB_OUTPUT-1:0] x_r, x_i, y_r, y_i;

    assign sw = sc[SCW-1];

    // sw=0: lane0 takes delayed A, B enters the lane-1 delay; sw=1: swapped
    always_comb begin
        x_r = a_dly_r[L_STAGE-1];
        x_i = a_dly_i[L_STAGE-1];
        y_r = s1_bf_r;
        y_i = s1_bf_i;
        if (sw) begin
            x_r = s1_bf_r;
            x_i = s1_bf_i;
            y_r = a_dly_r[L_STAGE-1];
            y_i = a_dly_i[L_STAGE-1];
        end
    end

    // L_STAGE-deep shift lines for A, for the lane-1 stream and for valid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < L_STAGE; k++) begin
                a_dly_r[k] <= '0;
                a_dly_i[k] <= '0;
                y_dly_r[k] <= '0;
                y_dly_i[k] <= '0;
            end
            v_dly <= '0;
        end else begin
            a_dly_r[0] <= s1_af_r;
            a_dly_i[0] <= s1_af_i;
            y_dly_r[0] <= y_r;
            y_dly_i[0] <= y_i;
            v_dly[0]   <= s0_valid;
            for (int k = 1; k < L_STAGE; k++) begin
                a_dly_r[k] <= a_dly_r[k-1];
                a_dly_i[k] <= a_dly_i[k-1];
                y_dly_r[k] <= y_dly_r[k-1];
                y_dly_i[k] <= y_dly_i[k-1];
                v_dly[k]   <= v_dly[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // output register
    // -------------------------------------------------------------------------
    // data only loads with a valid token so it holds across gaps
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_data1_r <= '0;
            o_data1_i <= '0;
            o_data2_r <= '0;
            o_data2_i <= '0;
        end else begin
            o_valid <= v_dly[L_STAGE-1];
            if (v_dly[L_STAGE-1]) begin
                o_data1_r <= x_r;
                o_data1_i <= x_i;
                o_data2_r <= y_dly_r[L_STAGE-1];
                o_data2_i <= y_dly_i[L_STAGE-1];
            end
        end
    end

endmodule

// File: tb/tb_mdc_r2_trivial_stage.sv
// -----------------------------------------------------------------------------
// tb_mdc_r2_trivial_stage
//   Directed bench for mdc_r2_trivial_stage. Instance u_s1 uses L_STAGE=1,
//   ROT_SPAN=1; instance u_s4 uses L_STAGE=4, ROT_SPAN=2. Expected values are
//   hand-computed exact S1 results; the round/scale build option is applied to
//   them through efmt().
// -----------------------------------------------------------------------------
module tb_mdc_r2_trivial_stage;

`ifdef MDC_R2_ROUND_SCALE_EN
    localparam int NBO = 10;
`else
    localparam int NBO = 11;
`endif

    logic clk = 1'b0;
    logic rst;
    logic inv;
    logic v1, v2;
    logic signed [9:0] d1r, d1i, d2r, d2i;

    logic                  o1_v, o2_v;
    logic signed [NBO-1:0] o1_1r, o1_1i, o1_2r, o1_2i;
    logic signed [NBO-1:0] o2_1r, o2_1i, o2_2r, o2_2i;

    always #5 clk = ~clk;

    mdc_r2_trivial_stage #(.NB_INPUT(10), .NB_OUTPUT(NBO), .L_STAGE(1), .ROT_SPAN(1)) u_s1 (
        .i_clk(clk), .i_rst(rst), .i_inverse(inv), .i_valid(v1),
        .i_data1_r(d1r), .i_data1_i(d1i), .i_data2_r(d2r), .i_data2_i(d2i),
        .o_valid(o1_v), .o_data1_r(o1_1r), .o_data1_i(o1_1i),
        .o_data2_r(o1_2r), .o_data2_i(o1_2i)
    );

    mdc_r2_trivial_stage #(.NB_INPUT(10), .NB_OUTPUT(NBO), .L_STAGE(4), .ROT_SPAN(2)) u_s4 (
        .i_clk(clk), .i_rst(rst), .i_inverse(inv), .i_valid(v2),
        .i_data1_r(d1r), .i_data1_i(d1i), .i_data2_r(d2r), .i_data2_i(d2i),
        .o_valid(o2_v), .o_data1_r(o2_1r), .o_data1_i(o2_1i),
        .o_data2_r(o2_2r), .o_data2_i(o2_2i)
    );

    int checks = 0;
    int errors = 0;

    // stimulus: valid, inverse, x0r, x0i, x1r, x1i; expected lane0 r/i, lane1 r/i
    int s_v   [32];
    int s_inv [32];
    int s_x   [32][4];
    int s_e   [32][4];
    int hold  [2][4];

    function automatic int efmt(input int v);
`ifdef MDC_R2_ROUND_SCALE_EN
        int t;
        t = (v + 1) >>> 1;
        if (t > 2**(NBO-1) - 1) t = 2**(NBO-1) - 1;
        return t;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input int v, input int iv,
                       input int x0r, input int x0i, input int x1r, input int x1i,
                       input int e0r, input int e0i, input int e1r, input int e1i);
        s_v[i]   = v;
        s_inv[i] = iv;
        s_x[i][0] = x0r; s_x[i][1] = x0i; s_x[i][2] = x1r; s_x[i][3] = x1i;
        s_e[i][0] = e0r; s_e[i][1] = e0i; s_e[i][2] = e1r; s_e[i][3] = e1i;
    endtask

    task automatic idle;
        v1 = 1'b0; v2 = 1'b0; inv = 1'b0;
        d1r = '0; d1i = '0; d2r = '0; d2i = '0;
    endtask

    task automatic drive(input int dut, input int t);
        v1  = (dut == 1) && (s_v[t] != 0);
        v2  = (dut == 2) && (s_v[t] != 0);
        inv = (s_inv[t] != 0);
        d1r = 10'(s_x[t][0]);
        d1i = 10'(s_x[t][1]);
        d2r = 10'(s_x[t][2]);
        d2i = 10'(s_x[t][3]);
    endtask

    // plays n stimulus entries and checks every cycle until the pipe drains
    task automatic run(input string name, input int dut, input int n);
        int lat, k, ev;
        logic signed [NBO-1:0] obs [4];
        logic                  obs_v;
        lat = (dut == 1) ? 2 : 5;
        for (int t = 0; t < n + lat + 1; t++) begin
            if (t < n) drive(dut, t);
            else       idle();
            tick();
            k  = t - lat;
            ev = (k >= 0 && k < n) ? s_v[k] : 0;
            obs_v  = (dut == 1) ? o1_v  : o2_v;
            obs[0] = (dut == 1) ? o1_1r : o2_1r;
            obs[1] = (dut == 1) ? o1_1i : o2_1i;
            obs[2] = (dut == 1) ? o1_2r : o2_2r;
            obs[3] = (dut == 1) ? o1_2i : o2_2i;
            chk($sformatf("%s c%0d o_valid", name, t), obs_v, ev);
            if (ev != 0)
                for (int q = 0; q < 4; q++) hold[dut-1][q] = efmt(s_e[k][q]);
            for (int q = 0; q < 4; q++)
                chk($sformatf("%s c%0d data%0d", name, t, q), obs[q], hold[dut-1][q]);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < 4; q++) hold[d][q] = 0;
        tick();
        tick();

        chk("por o_valid s1", o1_v, 0);
        chk("por o_valid s4", o2_v, 0);
        chk("por d1r", o1_1r, 0);
        chk("por d1i", o1_1i, 0);
        chk("por d2r", o1_2r, 0);
        chk("por d2i", o1_2i, 0);
        rst = 1'b0;
        tick();

        // forward: A=(4,3); B=(2,-1) and rotated (-1,-2) on odd samples
        put(0, 1, 0, 3, 1, 1, 2,  -1, -2,  2, -1);
        put(1, 1, 0, 3, 1, 1, 2,   4,  3,  4,  3);
        put(2, 1, 0, 3, 1, 1, 2,  -1, -2,  2, -1);
        put(3, 1, 0, 3, 1, 1, 2,   4,  3,  4,  3);
        run("fwd", 1, 4);

        // inverse: rotated B becomes (1,2)
        put(0, 1, 1, 3, 1, 1, 2,   1,  2,  2, -1);
        put(1, 1, 1, 3, 1, 1, 2,   4,  3,  4,  3);
        put(2, 1, 1, 3, 1, 1, 2,   1,  2,  2, -1);
        put(3, 1, 1, 3, 1, 1, 2,   4,  3,  4,  3);
        run("inv", 1, 4);

        // direction switched only for sample 1
        put(0, 1, 0, 3, 1, 1, 2,   1,  2,  2, -1);
        put(1, 1, 1, 3, 1, 1, 2,   4,  3,  4,  3);
        put(2, 1, 0, 3, 1, 1, 2,  -1, -2,  2, -1);
        put(3, 1, 0, 3, 1, 1, 2,   4,  3,  4,  3);
        run("invswitch", 1, 4);

        // extremes: A=-1024, B=-1023 rotated to +j*...(fwd gives imag 1023)
        put(0, 1, 0, -512, -512, -512, -512,   0, 1023,     0,     0);
        put(1, 1, 0, -512,    0,  511,    0,  -1,    0, -1024, -1024);
        run("edge_fwd", 1, 2);
        put(0, 1, 1, -512, -512, -512, -512,   0, -1023,    0,     0);
        put(1, 1, 1, -512,    0,  511,    0,  -1,     0, -1024, -1024);
        run("edge_inv", 1, 2);

        // one-sample frame, gap, then a full frame that must start at rc=sc=0
        put(0, 1, 0, 3, 1, 1, 2,   0,  0,  2, -1);
        put(1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0);
        put(2, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0);
        put(3, 1, 0, 3, 1, 1, 2,  -1, -2,  2, -1);
        put(4, 1, 0, 3, 1, 1, 2,   4,  3,  4,  3);
        put(5, 1, 0, 3, 1, 1, 2,  -1, -2,  2, -1);
        put(6, 1, 0, 3, 1, 1, 2,   4,  3,  4,  3);
        run("restart", 1, 7);

        // reset in the middle of a frame
        put(0, 1, 0, 3, 1, 1, 2,  -1, -2,  2, -1);
        put(1, 1, 0, 3, 1, 1, 2,   4,  3,  4,  3);
        put(2, 1, 0, 3, 1, 1, 2,  -1, -2,  2, -1);
        put(3, 1, 0, 3, 1, 1, 2,   4,  3,  4,  3);
        for (int t = 0; t < 3; t++) begin
            drive(1, t);
            tick();
        end
        chk("prerst o_valid", o1_v, 1);
        chk("prerst d1r", o1_1r, efmt(-1));
        #1 rst = 1'b1;
        #1;
        chk("midrst o_valid", o1_v, 0);
        chk("midrst d1r", o1_1r, 0);
        chk("midrst d1i", o1_1i, 0);
        chk("midrst d2r", o1_2r, 0);
        chk("midrst d2i", o1_2i, 0);
        idle();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int q = 0; q < 4; q++) hold[d][q] = 0;
        run("postrst", 1, 4);

        // L_STAGE=4, ROT_SPAN=2: 8-sample frame, 3-cycle gap, 8-sample frame
        put( 0, 1, 0,  1, 0, 0,  1,    5,  -5,   1,  -1);
        put( 1, 1, 0,  2, 0, 0,  2,    6,  -6,   2,  -2);
        put( 2, 1, 0,  3, 0, 0,  3,   -7,  -7,  -3,  -3);
        put( 3, 1, 0,  4, 0, 0,  4,   -8,  -8,  -4,  -4);
        put( 4, 1, 0,  5, 0, 0,  5,    5,   5,   1,   1);
        put( 5, 1, 0,  6, 0, 0,  6,    6,   6,   2,   2);
        put( 6, 1, 0,  7, 0, 0,  7,    7,   7,   3,   3);
        put( 7, 1, 0,  8, 0, 0,  8,    8,   8,   4,   4);
        put( 8, 0, 0,  0, 0, 0,  0,    0,   0,   0,   0);
        put( 9, 0, 0,  0, 0, 0,  0,    0,   0,   0,   0);
        put(10, 0, 0,  0, 0, 0,  0,    0,   0,   0,   0);
        put(11, 1, 0,  9, 0, 0,  9,   13, -13,   9,  -9);
        put(12, 1, 0, 10, 0, 0, 10,   14, -14,  10, -10);
        put(13, 1, 0, 11, 0, 0, 11,  -15, -15, -11, -11);
        put(14, 1, 0, 12, 0, 0, 12,  -16, -16, -12, -12);
        put(15, 1, 0, 13, 0, 0, 13,   13,  13,   9,   9);
        put(16, 1, 0, 14, 0, 0, 14,   14,  14,  10,  10);
        put(17, 1, 0, 15, 0, 0, 15,   15,  15,  11,  11);
        put(18, 1, 0, 16, 0, 0, 16,   16,  16,  12,  12);
        run("l4r2", 2, 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
